// File: rtl/lift_row_sequencer_pkg.sv
// Shared definitions for the lifting row sequencer: flag layout, the four
// pass flag codes presented to lift_step, and the sequencer state encoding.
package lift_row_sequencer_pkg;

  // Bit positions inside the 4-bit flags word; bit 3 is always zero.
  localparam int FlagPredictBit = 0;
  localparam int FlagFwdBit     = 1;
  localparam int FlagOneBit     = 2;

  localparam logic [3:0] FlagsFwdPredict =
    4'((1 << FlagOneBit) | (1 << FlagFwdBit) | (1 << FlagPredictBit));
  localparam logic [3:0] FlagsFwdUpdate  =
    4'((1 << FlagOneBit) | (1 << FlagFwdBit));
  localparam logic [3:0] FlagsInvPredict =
    4'((1 << FlagOneBit) | (1 << FlagPredictBit));
  localparam logic [3:0] FlagsInvUpdate  =
    4'(1 << FlagOneBit);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StIssue,
    StWait,
    StWr,
    StNext,
    StDone
  } seqState_e;

  // Select the flag code for the current direction and pass type.
  function automatic logic [3:0] makeFlags(input logic inverse, input logic isPredict);
    logic [3:0] f;
    case ({inverse, isPredict})
      2'b01:   f = FlagsFwdPredict;
      2'b00:   f = FlagsFwdUpdate;
      2'b11:   f = FlagsInvPredict;
      default: f = FlagsInvUpdate;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lift_row_sequencer_mirror_idx.sv
// Neighbour index generator with symmetric extension at both row ends:
// sample 0 borrows sample 1 as its left neighbour, sample W-1 borrows W-2
// as its right neighbour.
module lift_mirror_idx #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic [AW-1:0] i_idx,
  output logic [AW-1:0] o_leftIdx,
  output logic [AW-1:0] o_rightIdx
);

  localparam logic [AW-1:0] LastIdx   = AW'(W - 1);
  localparam logic [AW-1:0] PenultIdx = AW'(W - 2);
  localparam logic [AW-1:0] OneIdx    = AW'(1);

  // Mirror the out-of-row neighbour back into the row.
  always_comb begin
    o_leftIdx  = (i_idx == '0)      ? OneIdx    : i_idx - OneIdx;
    o_rightIdx = (i_idx == LastIdx) ? PenultIdx : i_idx + OneIdx;
  end

endmodule

// File: rtl/lift_row_sequencer.sv
// Row sequencer feeding lift_step: for each sample of a pass it reads the
// (left, sam, right) triple from a sync-read RAM, hands it to lift_step,
// waits for the result and writes it back in place. Two passes per row.
module lift_row_sequencer
  import lift_row_sequencer_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          inverse_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_rd_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    flags_o,
  output logic [DW-1:0] left_o,
  output logic [DW-1:0] sam_o,
  output logic [DW-1:0] right_o,
  output logic          lift_upd_o,
  input  logic [DW:0]   lift_res_i,
  input  logic          lift_done_i
);

  localparam logic [AW-1:0] LastPairIdx = AW'(W - 2);
  localparam logic [AW-1:0] StepIdx     = AW'(2);

  seqState_e     r_state;
  seqState_e     w_stateNext;
  logic [1:0]    r_rdCnt;
  logic [AW-1:0] r_idx;
  logic          r_pass;
  logic          r_inv;
  logic [DW-1:0] r_left;
  logic [DW-1:0] r_sam;
  logic [DW-1:0] r_right;
  logic [DW-1:0] r_res;
  logic [AW-1:0] w_leftIdx;
  logic [AW-1:0] w_rightIdx;
  logic          w_isPredict;
  logic          w_lastIdx;
  logic          w_unusedResMsb;

  // The written sample wraps to DW bits, so the result sign bit is not stored.
  assign w_unusedResMsb = lift_res_i[DW];

  // Forward runs predict first, inverse runs update first.
  assign w_isPredict = r_inv ? r_pass : ~r_pass;
  assign w_lastIdx   = (r_idx >= LastPairIdx);

  lift_mirror_idx #(
    .W  (W),
    .AW (AW)
  ) u_mirror (
    .i_idx      (r_idx),
    .o_leftIdx  (w_leftIdx),
    .o_rightIdx (w_rightIdx)
  );

  // State register; reset abandons any row in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode and all outputs; everything idles at zero.
  always_comb begin
    w_stateNext = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_addr_o  = '0;
    mem_rd_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    flags_o     = '0;
    left_o      = '0;
    sam_o       = '0;
    right_o     = '0;
    lift_upd_o  = 1'b0;
    case (r_state)
      StIdle: begin
        if (start_i) w_stateNext = StRd;
      end
      StRd: begin
        busy_o   = 1'b1;
        mem_rd_o = (r_rdCnt != 2'd3);
        case (r_rdCnt)
          2'd0:    mem_addr_o = w_leftIdx;
          2'd1:    mem_addr_o = r_idx;
          2'd2:    mem_addr_o = w_rightIdx;
          default: mem_addr_o = '0;
        endcase
        if (r_rdCnt == 2'd3) w_stateNext = StIssue;
      end
      StIssue: begin
        busy_o      = 1'b1;
        flags_o     = makeFlags(r_inv, w_isPredict);
        left_o      = r_left;
        sam_o       = r_sam;
        right_o     = r_right;
        lift_upd_o  = 1'b1;
        w_stateNext = StWait;
      end
      StWait: begin
        busy_o  = 1'b1;
        flags_o = makeFlags(r_inv, w_isPredict);
        left_o  = r_left;
        sam_o   = r_sam;
        right_o = r_right;
        if (lift_done_i) w_stateNext = StWr;
      end
      StWr: begin
        busy_o      = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = r_idx;
        mem_wdata_o = r_res;
        w_stateNext = StNext;
      end
      StNext: begin
        busy_o      = 1'b1;
        w_stateNext = (w_lastIdx && r_pass) ? StDone : StRd;
      end
      StDone: begin
        done_o      = 1'b1;
        w_stateNext = StIdle;
      end
      default: w_stateNext = StIdle;
    endcase
  end

  // Datapath: row position, pass tracking, read capture and result latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdCnt <= '0;
      r_idx   <= '0;
      r_pass  <= 1'b0;
      r_inv   <= 1'b0;
      r_left  <= '0;
      r_sam   <= '0;
      r_right <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_inv   <= inverse_i;
            r_pass  <= 1'b0;
            r_idx   <= inverse_i ? AW'(0) : AW'(1);
            r_rdCnt <= '0;
          end
        end
        StRd: begin
          r_rdCnt <= r_rdCnt + 2'd1;
          case (r_rdCnt)
            2'd1:    r_left  <= mem_rdata_i;
            2'd2:    r_sam   <= mem_rdata_i;
            2'd3:    r_right <= mem_rdata_i;
            default: ;
          endcase
        end
        StWait: begin
          if (lift_done_i) r_res <= lift_res_i[DW-1:0];
        end
        StNext: begin
          if (w_lastIdx) begin
            if (!r_pass) begin
              r_pass <= 1'b1;
              r_idx  <= r_inv ? AW'(1) : AW'(0);
            end
          end else begin
            r_idx <= r_idx + StepIdx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_row_sequencer.sv
// Self-checking bench for lift_row_sequencer on a 4-sample row, with a
// behavioural sync-read RAM and a behavioural lift_step with adjustable
// latency.
module tb_lift_row_sequencer;

  localparam int W  = 4;
  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          inverse_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_we_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    flags_o;
  logic [DW-1:0] left_o;
  logic [DW-1:0] sam_o;
  logic [DW-1:0] right_o;
  logic          lift_upd_o;
  logic [DW:0]   lift_res_i = '0;
  logic          lift_done_i = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] issue;
    logic [31:0] wr;
  } vec_t;
  vec_t vecs[8];

  logic [7:0]  mem [W];
  logic [31:0] loadVal = '0;
  logic        loadReq = 1'b0;

  int          liftDelay = 0;
  bit          forceRes = 1'b0;
  int          waitCnt = 0;
  bit          armed = 1'b0;
  logic [31:0] capIssue = '0;

  int          issueCnt = 0;
  int          wrCnt = 0;
  int          doneCnt = 0;
  int          stabErr = 0;
  int          bothErr = 0;
  logic [31:0] issueLog[64];
  logic [31:0] wrLog[64];

  lift_row_sequencer #(.W(W), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .inverse_i   (inverse_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rd_o    (mem_rd_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .flags_o     (flags_o),
    .left_o      (left_o),
    .sam_o       (sam_o),
    .right_o     (right_o),
    .lift_upd_o  (lift_upd_o),
    .lift_res_i  (lift_res_i),
    .lift_done_i (lift_done_i)
  );

  always #5 clk_i = ~clk_i;

  // 5/3 lifting step on unsigned samples; the result is kept to 9 bits.
  function automatic logic [8:0] liftModel(input logic [3:0] f, input logic [7:0] l,
                                           input logic [7:0] s, input logic [7:0] r);
    int sum;
    int res;
    sum = int'(l) + int'(r);
    case (f)
      4'd7:    res = int'(s) - (sum >> 1);
      4'd6:    res = int'(s) + ((sum + 2) >> 2);
      4'd5:    res = int'(s) + (sum >> 1);
      4'd4:    res = int'(s) - ((sum + 2) >> 2);
      default: res = 0;
    endcase
    return res[8:0];
  endfunction

  // Sync-read RAM with 1-cycle read latency, plus a bulk load port for the bench.
  always @(posedge clk_i) begin
    if (loadReq) begin
      for (int k = 0; k < W; k++) mem[k] <= loadVal[8*k +: 8];
    end else begin
      if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    end
  end

  // lift_step stand-in: result after liftDelay extra cycles, and a watch that
  // the triple and flags stay put for as long as the sequencer waits.
  always @(posedge clk_i) begin
    if (rst_i) begin
      lift_done_i <= 1'b0;
      armed       <= 1'b0;
      waitCnt     <= 0;
    end else begin
      if ((armed || lift_done_i) && ({4'd0, flags_o, left_o, sam_o, right_o} != capIssue))
        stabErr++;
      lift_done_i <= 1'b0;
      if (lift_upd_o) begin
        capIssue   <= {4'd0, flags_o, left_o, sam_o, right_o};
        lift_res_i <= forceRes ? 9'h12C : liftModel(flags_o, left_o, sam_o, right_o);
        if (liftDelay == 0) begin
          lift_done_i <= 1'b1;
          armed       <= 1'b0;
        end else begin
          armed   <= 1'b1;
          waitCnt <= liftDelay;
        end
      end else if (armed) begin
        if (waitCnt <= 1) begin
          lift_done_i <= 1'b1;
          armed       <= 1'b0;
        end
        waitCnt <= waitCnt - 1;
      end
    end
  end

  // Transaction monitor: every issue, every write, every done pulse.
  always @(posedge clk_i) begin
    if (lift_upd_o) begin
      if (issueCnt < 64) issueLog[issueCnt] = {4'd0, flags_o, left_o, sam_o, right_o};
      issueCnt++;
    end
    if (mem_we_o) begin
      if (wrCnt < 64) wrLog[wrCnt] = {22'd0, mem_addr_o, mem_wdata_o};
      wrCnt++;
    end
    if (done_o) doneCnt++;
    if (mem_rd_o && mem_we_o) bothErr++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] ramPack();
    logic [31:0] p;
    p = '0;
    for (int k = 0; k < W; k++) p[8*k +: 8] = mem[k];
    return p;
  endfunction

  task automatic loadRam(input logic [31:0] row);
    @(negedge clk_i);
    loadVal = row;
    loadReq = 1'b1;
    @(negedge clk_i);
    loadReq = 1'b0;
  endtask

  // Whole-row 5/3 transform in software, mod 256, from the current RAM image.
  task automatic computeExpected(input logic inv, output logic [31:0] exp);
    int t[W];
    int l;
    int r;
    bit pred;
    for (int k = 0; k < W; k++) t[k] = int'(mem[k]);
    for (int p = 0; p < 2; p++) begin
      pred = inv ? (p == 1) : (p == 0);
      for (int i = (pred ? 1 : 0); i < W; i += 2) begin
        l = (i == 0) ? t[1] : t[i-1];
        r = (i == W - 1) ? t[W-2] : t[i+1];
        if (pred) t[i] = inv ? t[i] + ((l + r) >> 1) : t[i] - ((l + r) >> 1);
        else      t[i] = inv ? t[i] - ((l + r + 2) >> 2) : t[i] + ((l + r + 2) >> 2);
        t[i] = t[i] & 255;
      end
    end
    exp = '0;
    for (int k = 0; k < W; k++) exp[8*k +: 8] = t[k][7:0];
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ctrl"}, {27'd0, busy_o, done_o, mem_rd_o, mem_we_o, lift_upd_o}, 32'd0);
    checkOutput({tag, "_data"}, {left_o, sam_o, right_o, mem_wdata_o}, 32'd0);
    checkOutput({tag, "_addrFlags"}, {26'd0, mem_addr_o, flags_o}, 32'd0);
  endtask

  // Run one row from the current RAM contents and check the row-level results.
  task automatic applyStimulus(input logic inv, input int delay, input bit noisy,
                               input string tag, output int iB, output int wB);
    logic [31:0] expRow;
    int dB;
    bit finished;
    logic busyAtDone;
    computeExpected(inv, expRow);
    liftDelay  = delay;
    iB         = issueCnt;
    wB         = wrCnt;
    dB         = doneCnt;
    finished   = 1'b0;
    busyAtDone = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b1;
    inverse_i = inv;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput({tag, "_busyAfterStart"}, {31'd0, busy_o}, 32'd1);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk_i);
      start_i   = 1'b0;
      inverse_i = inv;
      if (doneCnt != dB) begin
        finished = 1'b1;
      end else begin
        if (done_o) busyAtDone = busy_o;
        if (noisy && (cyc == 10 || done_o)) begin
          start_i   = 1'b1;
          inverse_i = ~inv;
        end
      end
    end
    start_i = 1'b0;
    checkOutput({tag, "_finished"}, {31'd0, finished}, 32'd1);
    checkOutput({tag, "_busyAtDone"}, {31'd0, busyAtDone}, 32'd0);
    checkOutput({tag, "_idleAfterDone"}, {31'd0, busy_o}, 32'd0);
    checkOutput({tag, "_doneCount"}, doneCnt - dB, 32'd1);
    checkOutput({tag, "_writeCount"}, wrCnt - wB, W);
    checkOutput({tag, "_issueCount"}, issueCnt - iB, W);
    checkOutput({tag, "_stable"}, stabErr, 32'd0);
    checkOutput({tag, "_rdWeExclusive"}, bothErr, 32'd0);
    if (!forceRes) checkOutput({tag, "_ram"}, ramPack(), expRow);
  endtask

  // Compare the logged issues and writes of one row against the vector table.
  task automatic checkTable(input int first, input int iB, input int wB, input string tag);
    for (int k = 0; k < W; k++) begin
      checkOutput($sformatf("%s_issue%0d", tag, k), issueLog[iB + k], vecs[first + k].issue);
      checkOutput($sformatf("%s_write%0d", tag, k), wrLog[wB + k], vecs[first + k].wr);
    end
  endtask

  initial begin
    int iB;
    int wB;
    int dB;
    bit reached;

    // Row [68,218,163,164]: forward issues/writes, then inverse on the result.
    vecs[0] = '{{4'd0, 4'd7, 8'd68,  8'd218, 8'd163}, {22'd0, 2'd1, 8'd103}};
    vecs[1] = '{{4'd0, 4'd7, 8'd163, 8'd164, 8'd163}, {22'd0, 2'd3, 8'd1}};
    vecs[2] = '{{4'd0, 4'd6, 8'd103, 8'd68,  8'd103}, {22'd0, 2'd0, 8'd120}};
    vecs[3] = '{{4'd0, 4'd6, 8'd103, 8'd163, 8'd1},   {22'd0, 2'd2, 8'd189}};
    vecs[4] = '{{4'd0, 4'd4, 8'd103, 8'd120, 8'd103}, {22'd0, 2'd0, 8'd68}};
    vecs[5] = '{{4'd0, 4'd4, 8'd103, 8'd189, 8'd1},   {22'd0, 2'd2, 8'd163}};
    vecs[6] = '{{4'd0, 4'd5, 8'd68,  8'd103, 8'd163}, {22'd0, 2'd1, 8'd218}};
    vecs[7] = '{{4'd0, 4'd5, 8'd163, 8'd1,   8'd163}, {22'd0, 2'd3, 8'd164}};

    repeat (3) @(negedge clk_i);
    checkIdle("inReset");
    rst_i = 1'b0;
    @(negedge clk_i);
    checkIdle("afterReset");

    loadRam({8'd164, 8'd163, 8'd218, 8'd68});
    applyStimulus(1'b0, 0, 1'b0, "fwd", iB, wB);
    checkTable(0, iB, wB, "fwd");
    checkOutput("fwdRow", ramPack(), {8'd1, 8'd189, 8'd103, 8'd120});

    applyStimulus(1'b1, 1, 1'b0, "inv", iB, wB);
    checkTable(4, iB, wB, "inv");
    checkOutput("restoredRow", ramPack(), {8'd164, 8'd163, 8'd218, 8'd68});

    loadRam({8'd77, 8'd0, 8'd250, 8'd10});
    applyStimulus(1'b0, 5, 1'b0, "fwdDly5", iB, wB);
    applyStimulus(1'b1, 1, 1'b0, "invDly1", iB, wB);
    checkOutput("restoredRow2", ramPack(), {8'd77, 8'd0, 8'd250, 8'd10});

    // Reset while waiting on lift_step for sample 3 of the forward predict pass.
    loadRam({8'd164, 8'd163, 8'd218, 8'd68});
    liftDelay = 5;
    iB = issueCnt;
    wB = wrCnt;
    dB = doneCnt;
    reached = 1'b0;
    @(negedge clk_i);
    start_i   = 1'b1;
    inverse_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
      if (issueCnt - iB >= 2) reached = 1'b1;
      else @(negedge clk_i);
    end
    checkOutput("rstWait_reached", {31'd0, reached}, 32'd1);
    checkOutput("rstWait_flags", {28'd0, flags_o}, 32'd7);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkIdle("rstWait");
    rst_i = 1'b0;
    checkOutput("rstWait_writes", wrCnt - wB, 32'd1);
    checkOutput("rstWait_noDone", doneCnt - dB, 32'd0);
    @(negedge clk_i);
    applyStimulus(1'b0, 0, 1'b0, "afterRst", iB, wB);

    // Start pulses while busy and on the done cycle must be ignored.
    loadRam({8'd9, 8'd200, 8'd33, 8'd128});
    applyStimulus(1'b0, 2, 1'b1, "noisy", iB, wB);
    dB = doneCnt;
    repeat (40) @(negedge clk_i);
    checkOutput("noisy_staysIdle", {31'd0, busy_o}, 32'd0);
    checkOutput("noisy_noExtraDone", doneCnt - dB, 32'd0);

    // A 9-bit result of 300 wraps to 44 on the write port.
    forceRes = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, "wrap", iB, wB);
    forceRes = 1'b0;
    checkOutput("wrap300_first", {24'd0, wrLog[wB][7:0]}, 32'd44);
    checkOutput("wrap300_last", {24'd0, wrLog[wB + 3][7:0]}, 32'd44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
